pixel_writer: RTL and testbench

PIXEL_WRITER -- requirements
Module: pixel_writer

---
 rtl/gpu_pkg.sv | 38 +++
 rtl/pixel_fifo.sv | 70 +++++++
 rtl/pixel_writer.sv | 148 ++++++++++++++
 tb/tb_pixel_writer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: framebuffer geometry, coordinate/colour types,
// pixel-writer state encoding and the queued pixel record.
package gpu_pkg;

    localparam int unsigned FB_WIDTH_DEFAULT  = 320;
    localparam int unsigned FB_HEIGHT_DEFAULT = 240;
    localparam int unsigned FB_ADDR_W         = 17;
    localparam int unsigned COORD_W           = 9;
    localparam int unsigned COLOR_W           = 8;

    typedef logic [COORD_W-1:0]   coord_t;
    typedef logic [COLOR_W-1:0]   color_t;
    typedef logic [FB_ADDR_W-1:0] fb_addr_t;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } pw_state_t;

    // One queued write: framebuffer word address plus colour.
    typedef struct packed {
        fb_addr_t addr;
        color_t   color;
    } pixel_entry_t;

    localparam int unsigned ENTRY_W = $bits(pixel_entry_t);

    // Linear framebuffer address y*width + x, evaluated at full address width
    // so nothing is truncated. With a constant width the multiply reduces to
    // shifts and adds ((y<<8)+(y<<6)+x for a 320-pixel line).
    function automatic fb_addr_t pixel_address(input coord_t x, input coord_t y,
                                               input int unsigned width);
        fb_addr_t prod;
        prod = fb_addr_t'(y) * fb_addr_t'(width);
        return prod + fb_addr_t'(x);
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO for queued pixel writes. Pointers carry one extra
// wrap bit so full and empty are distinguishable; DEPTH must be a power of two.
module pixel_fifo #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    rd_ptr_d;
    logic             wr_en;
    logic             rd_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // A push into a full queue still succeeds when the head leaves on the
    // same edge: the freed slot is the one being written.
    assign rd_en = pop_i && !empty_o;
    assign wr_en = push_i && (!full_o || rd_en);

    // Head entry is presented combinationally; the consumer registers it.
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Next-state pointer arithmetic, wrapping naturally modulo 2*DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Pointer registers; reset empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array, no reset so it maps onto distributed/block memory.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/pixel_writer.sv
// Pixel writer: clips incoming pixels against the framebuffer, converts
// (x,y) to a linear address, queues them and drains the queue into a
// framebuffer write port with a valid/ready style handshake.
module pixel_writer
    import gpu_pkg::*;
#(
    parameter int unsigned FB_WIDTH   = FB_WIDTH_DEFAULT,
    parameter int unsigned FB_HEIGHT  = FB_HEIGHT_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [COORD_W-1:0]   pixel_x,
    input  logic [COORD_W-1:0]   pixel_y,
    input  logic [COLOR_W-1:0]   pixel_color,
    input  logic                 pixel_valid,
    input  logic                 clear_flags,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [COLOR_W-1:0]   fb_data,
    output logic                 fb_we,
    input  logic                 fb_ready,
    output logic                 busy,
    output logic                 overflow,
    output logic                 clipped
);

    localparam logic [COORD_W:0] X_LIM = (COORD_W+1)'(FB_WIDTH);
    localparam logic [COORD_W:0] Y_LIM = (COORD_W+1)'(FB_HEIGHT);

    pw_state_t     state_q;
    pw_state_t     state_d;
    logic          accept_en_q;
    logic [FB_ADDR_W-1:0] fb_addr_q;
    logic [FB_ADDR_W-1:0] fb_addr_d;
    logic [COLOR_W-1:0]   fb_data_q;
    logic [COLOR_W-1:0]   fb_data_d;
    logic          overflow_q;
    logic          overflow_d;
    logic          clipped_q;
    logic          clipped_d;

    logic          pix_take;
    logic          off_screen;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    pixel_entry_t  push_entry;
    pixel_entry_t  head_entry;
    logic [ENTRY_W-1:0] head_bits;

    // Input side: gate, classify and address the incoming pixel.
    assign pix_take   = pixel_valid && accept_en_q;
    assign off_screen = ({1'b0, pixel_x} >= X_LIM) || ({1'b0, pixel_y} >= Y_LIM);
    assign push       = pix_take && !off_screen;

    assign push_entry.addr  = pixel_address(pixel_x, pixel_y, FB_WIDTH);
    assign push_entry.color = pixel_color;
    assign head_entry       = pixel_entry_t'(head_bits);

    pixel_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_entry),
        .rdata_o (head_bits),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Pixels are ignored on the first edge after reset release; this flag
    // rises on that edge so acceptance starts on the second one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            accept_en_q <= 1'b0;
        end else begin
            accept_en_q <= 1'b1;
        end
    end

    // Write FSM next state: load the head into the output registers whenever
    // the port is free (IDLE) or the current write is being accepted.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    fb_addr_d = head_entry.addr;
                    fb_data_d = head_entry.color;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                if (fb_ready) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        fb_addr_d = head_entry.addr;
                        fb_data_d = head_entry.color;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sticky flags: a new event on the same edge as a clear keeps the flag set.
    always_comb begin
        overflow_d = (overflow_q && !clear_flags) || (push && fifo_full && !pop);
        clipped_d  = (clipped_q && !clear_flags) || (pix_take && off_screen);
    end

    // State, output data and flag registers; reset abandons any write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
            overflow_q <= 1'b0;
            clipped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
            overflow_q <= overflow_d;
            clipped_q  <= clipped_d;
        end
    end

    assign fb_we    = (state_q == WRITE);
    assign fb_addr  = fb_addr_q;
    assign fb_data  = fb_data_q;
    assign busy     = !fifo_empty || (state_q == WRITE);
    assign overflow = overflow_q;
    assign clipped  = clipped_q;

endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer: a table of single-pixel vectors plus
// hand-written multi-cycle sequences (burst, clipping, stall, reset).
module tb_pixel_writer;

    logic        clk;
    logic        reset;
    logic [8:0]  pixel_x;
    logic [8:0]  pixel_y;
    logic [7:0]  pixel_color;
    logic        pixel_valid;
    logic        clear_flags;
    logic [16:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fb_we;
    logic        fb_ready;
    logic        busy;
    logic        overflow;
    logic        clipped;

    pixel_writer dut (
        .clk         (clk),
        .reset       (reset),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_color (pixel_color),
        .pixel_valid (pixel_valid),
        .clear_flags (clear_flags),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .fb_we       (fb_we),
        .fb_ready    (fb_ready),
        .busy        (busy),
        .overflow    (overflow),
        .clipped     (clipped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [16:0] wr_addr_log [$];
    logic [7:0]  wr_data_log [$];
    int          wr_cyc_log  [$];

    logic        stall_pending = 1'b0;
    logic [16:0] held_addr;
    logic [7:0]  held_data;

    typedef struct {
        logic [8:0]  x;
        logic [8:0]  y;
        logic [7:0]  color;
        logic        clip;
        logic [16:0] addr;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("[TB] pass %s = 0x%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_log();
        wr_addr_log.delete();
        wr_data_log.delete();
        wr_cyc_log.delete();
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
    endtask

    task automatic drive_pixel(input logic [8:0] x, input logic [8:0] y, input logic [7:0] c);
        pixel_valid = 1'b1;
        pixel_x     = x;
        pixel_y     = y;
        pixel_color = c;
        tick();
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: logs accepted writes and checks that a stalled write
    // keeps its address and data until the framebuffer takes it.
    always @(negedge clk) begin
        if (!reset) begin
            stall_pending = 1'b0;
        end else begin
            if (stall_pending) begin
                check("hold_we", 32'(fb_we), 32'd1);
                check("hold_addr", 32'(fb_addr), 32'(held_addr));
                check("hold_data", 32'(fb_data), 32'(held_data));
            end
            if (fb_we && fb_ready) begin
                wr_addr_log.push_back(fb_addr);
                wr_data_log.push_back(fb_data);
                wr_cyc_log.push_back(cyc);
                $display("[TB] write cyc=%0d addr=%0d data=0x%02h", cyc, fb_addr, fb_data);
            end
            stall_pending = fb_we && !fb_ready;
            held_addr     = fb_addr;
            held_data     = fb_data;
        end
    end

    initial begin
        reset       = 1'b0;
        pixel_valid = 1'b0;
        pixel_x     = '0;
        pixel_y     = '0;
        pixel_color = '0;
        clear_flags = 1'b0;
        fb_ready    = 1'b1;

        vecs[0]  = '{9'd5,   9'd5,   8'hFF, 1'b0, 17'd1605};
        vecs[1]  = '{9'd0,   9'd0,   8'h01, 1'b0, 17'd0};
        vecs[2]  = '{9'd319, 9'd239, 8'h02, 1'b0, 17'd76799};
        vecs[3]  = '{9'd320, 9'd0,   8'h03, 1'b1, 17'd0};
        vecs[4]  = '{9'd0,   9'd240, 8'h04, 1'b1, 17'd0};
        vecs[5]  = '{9'd1,   9'd0,   8'h05, 1'b0, 17'd1};
        vecs[6]  = '{9'd0,   9'd1,   8'h06, 1'b0, 17'd320};
        vecs[7]  = '{9'd100, 9'd200, 8'h07, 1'b0, 17'd64100};
        vecs[8]  = '{9'd511, 9'd511, 8'h08, 1'b1, 17'd0};
        vecs[9]  = '{9'd319, 9'd0,   8'h09, 1'b0, 17'd319};
        vecs[10] = '{9'd0,   9'd239, 8'h0A, 1'b0, 17'd76480};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_fb_we", 32'(fb_we), 32'd0);
        check("rst_fb_addr", 32'(fb_addr), 32'd0);
        check("rst_fb_data", 32'(fb_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_clipped", 32'(clipped), 32'd0);

        // Pixel on the first edge after release must be ignored
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive_pixel(9'd7, 9'd7, 8'h11);
        pixel_valid = 1'b0;
        idle(5);
        @(negedge clk);
        check("first_edge_ignored_writes", 32'(wr_addr_log.size()), 32'd0);
        check("first_edge_ignored_busy", 32'(busy), 32'd0);

        // Single pixel: latency and single-cycle write
        tick();
        clear_log();
        drive_pixel(9'd5, 9'd5, 8'hFF);
        pixel_valid = 1'b0;
        @(negedge clk);
        check("single_we_edgeN", 32'(fb_we), 32'd0);
        check("single_busy_edgeN", 32'(busy), 32'd1);
        tick();
        @(negedge clk);
        check("single_we_edgeN1", 32'(fb_we), 32'd1);
        check("single_addr", 32'(fb_addr), 32'd1605);
        check("single_data", 32'(fb_data), 32'hFF);
        tick();
        @(negedge clk);
        check("single_we_after", 32'(fb_we), 32'd0);
        check("single_busy_after", 32'(busy), 32'd0);
        check("single_write_count", 32'(wr_addr_log.size()), 32'd1);

        // Table of single-pixel vectors
        for (int i = 0; i < 11; i++) begin
            tick();
            pulse_clear();
            clear_log();
            drive_pixel(vecs[i].x, vecs[i].y, vecs[i].color);
            pixel_valid = 1'b0;
            idle(5);
            @(negedge clk);
            check($sformatf("vec%0d_writes", i), 32'(wr_addr_log.size()),
                  vecs[i].clip ? 32'd0 : 32'd1);
            check($sformatf("vec%0d_clipped", i), 32'(clipped), 32'(vecs[i].clip));
            if (!vecs[i].clip && wr_addr_log.size() == 1) begin
                check($sformatf("vec%0d_addr", i), 32'(wr_addr_log[0]), 32'(vecs[i].addr));
                check($sformatf("vec%0d_data", i), 32'(wr_data_log[0]), 32'(vecs[i].color));
            end
        end

        // Diagonal (0,0)..(5,5), back-to-back
        tick();
        pulse_clear();
        clear_log();
        for (int i = 0; i < 6; i++) begin
            drive_pixel(9'(i), 9'(i), 8'(8'h20 + i));
        end
        pixel_valid = 1'b0;
        idle(6);
        @(negedge clk);
        check("diag_writes", 32'(wr_addr_log.size()), 32'd6);
        if (wr_addr_log.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("diag_addr%0d", i), 32'(wr_addr_log[i]), 32'(i * 321));
            end
            check("diag_contiguous", 32'(wr_cyc_log[5] - wr_cyc_log[0]), 32'd5);
        end
        check("diag_overflow", 32'(overflow), 32'd0);

        // 12-pixel burst while the framebuffer stalls for 20 cycles
        tick();
        pulse_clear();
        clear_log();
        fb_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive_pixel(9'(i), 9'd10, 8'(i + 1));
        end
        pixel_valid = 1'b0;
        idle(8);
        @(negedge clk);
        check("burst_overflow", 32'(overflow), 32'd1);
        check("burst_no_writes_yet", 32'(wr_addr_log.size()), 32'd0);
        check("burst_we_stalled", 32'(fb_we), 32'd1);
        check("burst_head_addr", 32'(fb_addr), 32'd3200);
        fb_ready = 1'b1;
        idle(14);
        @(negedge clk);
        check("burst_writes", 32'(wr_addr_log.size()), 32'd9);
        if (wr_addr_log.size() == 9) begin
            for (int i = 0; i < 9; i++) begin
                check($sformatf("burst_addr%0d", i), 32'(wr_addr_log[i]), 32'(3200 + i));
                check($sformatf("burst_data%0d", i), 32'(wr_data_log[i]), 32'(i + 1));
            end
        end
        check("burst_busy_done", 32'(busy), 32'd0);

        // Clipping at the edges plus flag clear behaviour
        tick();
        pulse_clear();
        clear_log();
        drive_pixel(9'd319, 9'd239, 8'h5A);
        drive_pixel(9'd320, 9'd0, 8'h5B);
        drive_pixel(9'd0, 9'd240, 8'h5C);
        pixel_valid = 1'b0;
        idle(5);
        @(negedge clk);
        check("clip_writes", 32'(wr_addr_log.size()), 32'd1);
        if (wr_addr_log.size() == 1) begin
            check("clip_addr", 32'(wr_addr_log[0]), 32'd76799);
            check("clip_data", 32'(wr_data_log[0]), 32'h5A);
        end
        check("clip_flag_set", 32'(clipped), 32'd1);
        check("clip_no_overflow", 32'(overflow), 32'd0);
        tick();
        pulse_clear();
        @(negedge clk);
        check("clip_flag_cleared", 32'(clipped), 32'd0);
        tick();
        clear_flags = 1'b1;
        drive_pixel(9'd400, 9'd0, 8'h00);
        pixel_valid = 1'b0;
        clear_flags = 1'b0;
        @(negedge clk);
        check("clip_event_beats_clear", 32'(clipped), 32'd1);

        // fb_ready toggling during a 6-pixel line
        tick();
        pulse_clear();
        clear_log();
        for (int t = 0; t < 30; t++) begin
            fb_ready = ((t % 2) == 1);
            if (t < 6) begin
                pixel_valid = 1'b1;
                pixel_x     = 9'(10 + t);
                pixel_y     = 9'd3;
                pixel_color = 8'(8'h40 + t);
            end else begin
                pixel_valid = 1'b0;
            end
            tick();
        end
        fb_ready = 1'b1;
        idle(3);
        @(negedge clk);
        check("toggle_writes", 32'(wr_addr_log.size()), 32'd6);
        if (wr_addr_log.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("toggle_addr%0d", i), 32'(wr_addr_log[i]), 32'(970 + i));
                check($sformatf("toggle_data%0d", i), 32'(wr_data_log[i]), 32'(8'h40 + i));
            end
        end
        check("toggle_overflow", 32'(overflow), 32'd0);

        // Reset asserted mid-write with three entries queued
        tick();
        pulse_clear();
        clear_log();
        fb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_pixel(9'(20 + i), 9'd4, 8'(8'h70 + i));
        end
        drive_pixel(9'd500, 9'd0, 8'h00);
        pixel_valid = 1'b0;
        idle(2);
        @(negedge clk);
        check("midrst_we_before", 32'(fb_we), 32'd1);
        check("midrst_clipped_before", 32'(clipped), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_fb_we", 32'(fb_we), 32'd0);
        check("midrst_fb_addr", 32'(fb_addr), 32'd0);
        check("midrst_fb_data", 32'(fb_data), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        check("midrst_clipped", 32'(clipped), 32'd0);
        repeat (2) @(posedge clk);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        fb_ready = 1'b1;
        clear_log();
        drive_pixel(9'd30, 9'd30, 8'hA0);
        drive_pixel(9'd31, 9'd30, 8'hA1);
        pixel_valid = 1'b0;
        idle(6);
        @(negedge clk);
        check("postrst_writes", 32'(wr_addr_log.size()), 32'd1);
        if (wr_addr_log.size() == 1) begin
            check("postrst_addr", 32'(wr_addr_log[0]), 32'd9631);
            check("postrst_data", 32'(wr_data_log[0]), 32'hA1);
        end
        check("postrst_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
